qsv_mac_ctrl: RTL and testbench
===============================

Name: qsv_mac_ctrl

Overview:
Sequencer for the signed complex arithmetic unit (CAU) in the QFT state-vector datapath. It replaces the fixed single-qubit controller with one parametrised in qubit count and multiplier latency. On each start it issues read addresses for a 2^N x 2^N gate matrix and a 2^N state vector. It then drives accumulate and write-back strobes through a latency-matched tag pipeline and supports mat-vec, element-wise add and magnitude-squared modes.

Parameters:
N_QUBITS, 2, qubit count; DIM = 2**N_QUBITS amplitudes; legal range 1 to 8.
MUL_LAT, 2, CAU multiplier pipeline depth in cycles; legal range 1 to 8. PIPE = 1 + MUL_LAT, which includes the 1-cycle memory read latency.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request a run; sampled only in IDLE
op  in  2  mode: 00 MATVEC, 01 ABS, 10 ADD, 11 NORM (legal only with the optional feature)
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse at the end of a run
err  out  1  one-cycle pulse, coincident with done, on an illegal op
rd_en  out  1  read strobe to the matrix and vector memories
rd_row  out  N_QUBITS  matrix row index
rd_col  out  N_QUBITS  matrix column index, which is also the vector index
mode_abs  out  1  CAU computes |x|^2; latched op, held for the whole run
mode_add  out  1  CAU adds instead of multiplying; latched op, held for the whole run
acc_en  out  1  accumulator update, aligned to CAU output
acc_clr  out  1  with acc_en: load the accumulator instead of adding
wr_en  out  1  write the accumulator result back
wr_addr  out  N_QUBITS  destination amplitude index

Behaviour:
- Reset values: all outputs are 0, state is IDLE, counters are 0 and all pipeline valid bits are cleared.
- Reset mid-run aborts immediately. No wr_en or done is produced for in-flight tags.
- States: IDLE, ISSUE, DRAIN, DONE, ERR.
- IDLE:
  - start=1 with a legal op latches op, clears row and col, and goes to ISSUE.
  - start=1 with an illegal op goes to ERR.
- start while not in IDLE is ignored.
- ERR lasts one cycle with done=1, err=1 and busy=1, then goes to IDLE. No rd_en is issued.
- ISSUE: every cycle rd_en=1, with rd_row/rd_col taken from the counters. A tag {valid, first, last, row} enters the PIPE-deep shift register.
- MATVEC:
  - col increments every cycle; on col wrap to 0, row increments.
  - first = (col==0), last = (col==DIM-1).
  - DIM*DIM issue cycles.
- ABS and ADD:
  - col steps 0 to DIM-1 and row = col.
  - first = last = 1 for every element.
  - DIM issue cycles.
- ISSUE goes to DRAIN on the cycle after the final issue. rd_en=0 outside ISSUE.
- DRAIN lasts exactly PIPE cycles, then goes to DONE.
- DONE lasts one cycle with done=1, then goes to IDLE. busy drops in the cycle after DONE.
- Pipeline output: a tag issued in cycle t appears in cycle t+PIPE. At that cycle:
  - acc_en = valid
  - acc_clr = valid & first
  - wr_en = valid & last
  - wr_addr = tag row
- The final wr_en therefore coincides with the last DRAIN cycle. done follows one cycle later.
- Latency from the start-sample cycle to done is ISSUE_CYCLES + PIPE + 1.
- Counters are N_QUBITS bits wide and wrap naturally. The end of issue is detected by compare, not by overflow.

Optional Feature:
QSV_NORM_EN:
- Defined: op=11 is legal (NORM).
  - mode_abs=1.
  - col steps 0 to DIM-1 with rd_row=0.
  - first only on col 0 and last only on col DIM-1, so the unit accumulates sum |x|^2 over all amplitudes.
  - Exactly one wr_en, with wr_addr=0.
  - DIM issue cycles.
- Undefined: op=11 goes to ERR.

Test Plan:
- N_QUBITS=2, MUL_LAT=2, MATVEC, start at cycle 0:
  - rd_en high on cycles 1-16 with (row,col) = (0,0),(0,1),...,(3,3).
  - acc_clr on cycles 4, 8, 12, 16.
  - wr_en on cycles 7, 11, 15, 19 with wr_addr 0 to 3.
  - done on cycle 20; busy high on cycles 1-20.
- ABS, N_QUBITS=2: rd_en on cycles 1-4; acc_clr and wr_en on cycles 4-7 with wr_addr 0 to 3; done on cycle 8; mode_abs=1 on cycles 1-8.
- op=11 without QSV_NORM_EN: err=done=1 on cycle 1, no rd_en/wr_en, back in IDLE on cycle 2. With the macro, NORM gives a single wr_en on cycle 7 with wr_addr=0 and done on cycle 8.
- start pulsed on cycles 3 and 10 during a MATVEC run: both ignored, no change in the issue sequence.
- rst asserted on cycle 9 of MATVEC: all outputs 0 on cycle 10, no wr_en afterwards. A new ADD started on cycle 12 completes normally.
- N_QUBITS=1, MUL_LAT=1, MATVEC: 4 issues on cycles 1-4, wr_en on cycles 4 and 6, done on cycle 7.

Source files
------------

// File: rtl/qsv_mac_ctrl.sv
// CAU sequencer for the QFT state-vector datapath: matrix/vector read issue plus latency-matched tags.
// Build option: define QSV_NORM_EN to make op=11 (NORM, sum of |x|^2) legal.
module qsv_mac_ctrl #(
    parameter int N_QUBITS = 2,
    parameter int MUL_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rd_en,
    output logic [N_QUBITS-1:0] rd_row,
    output logic [N_QUBITS-1:0] rd_col,
    output logic                mode_abs,
    output logic                mode_add,
    output logic                acc_en,
    output logic                acc_clr,
    output logic                wr_en,
    output logic [N_QUBITS-1:0] wr_addr
);

    localparam int PIPE = 1 + MUL_LAT;
    localparam logic [N_QUBITS-1:0] IDX_MAX = '1;
    localparam logic [3:0] DRN_LAST = 4'(PIPE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_MATVEC = 2'b00,
        OP_ABS    = 2'b01,
        OP_ADD    = 2'b10,
        OP_NORM   = 2'b11
    } op_t;

    typedef struct packed {
        logic                valid;
        logic                first;
        logic                last;
        logic [N_QUBITS-1:0] row;
    } tag_t;

    state_t              state_q;
    state_t              state_d;
    op_t                 op_q;
    logic [N_QUBITS-1:0] row_q;
    logic [N_QUBITS-1:0] col_q;
    logic [3:0]          drn_q;
    tag_t                pipe_q [PIPE];
    tag_t                tag_in;

    logic                op_legal;
    logic                accept;
    logic                issuing;
    logic                running;
    logic                issue_last;
    logic                drain_last;
    logic [N_QUBITS-1:0] row_sel;
    logic                tag_first;
    logic                tag_last;

`ifdef QSV_NORM_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = (op != OP_NORM);
`endif

    assign accept     = (state_q == IDLE) && start && op_legal;
    assign issuing    = (state_q == ISSUE);
    assign running    = (state_q == ISSUE) || (state_q == DRAIN) ||
                        (state_q == DONE);
    assign drain_last = (drn_q == DRN_LAST);

    // End of issue is a compare on the counters, never a wrap detect.
    always_comb begin
        issue_last = 1'b0;
        if (op_q == OP_MATVEC)
            issue_last = (row_q == IDX_MAX) && (col_q == IDX_MAX);
        else
            issue_last = (col_q == IDX_MAX);
    end

    always_comb begin
        row_sel   = '0;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        case (op_q)
            OP_MATVEC: begin
                row_sel   = row_q;
                tag_first = (col_q == '0);
                tag_last  = (col_q == IDX_MAX);
            end
            OP_ABS, OP_ADD: begin
                row_sel   = col_q;
                tag_first = 1'b1;
                tag_last  = 1'b1;
            end
            default: begin
                row_sel   = '0;
                tag_first = (col_q == '0);
                tag_last  = (col_q == IDX_MAX);
            end
        endcase
    end

    always_comb begin
        tag_in = '0;
        if (issuing) begin
            tag_in.valid = 1'b1;
            tag_in.first = tag_first;
            tag_in.last  = tag_last;
            tag_in.row   = row_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = op_legal ? ISSUE : ERR;
            end
            ISSUE: begin
                if (issue_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_last)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_MATVEC;
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            op_q  <= op_t'(op);
            row_q <= '0;
            col_q <= '0;
        end else if (issuing) begin
            col_q <= col_q + 1'b1;
            if (op_q == OP_MATVEC && col_q == IDX_MAX)
                row_q <= row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            drn_q <= '0;
        else if (state_q == DRAIN)
            drn_q <= drn_q + 4'd1;
        else
            drn_q <= '0;
    end

    // Tag delay line matches memory read plus multiplier depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++)
                pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < PIPE; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE) || (state_q == ERR);
        err      = (state_q == ERR);
        rd_en    = issuing;
        rd_row   = issuing ? row_sel : '0;
        rd_col   = issuing ? col_q : '0;
        mode_abs = running && ((op_q == OP_ABS) || (op_q == OP_NORM));
        mode_add = running && (op_q == OP_ADD);
        acc_en   = pipe_q[PIPE-1].valid;
        acc_clr  = pipe_q[PIPE-1].valid & pipe_q[PIPE-1].first;
        wr_en    = pipe_q[PIPE-1].valid & pipe_q[PIPE-1].last;
        wr_addr  = pipe_q[PIPE-1].row;
    end

endmodule

// File: tb/tb_qsv_mac_ctrl.sv
// Table-driven bench for qsv_mac_ctrl: per-cycle traces checked against hand-derived vectors.
// Honors QSV_NORM_EN for the op=11 expectations.
module tb_qsv_mac_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       rd_en;
        logic [1:0] rd_row;
        logic [1:0] rd_col;
        logic       mode_abs;
        logic       mode_add;
        logic       acc_en;
        logic       acc_clr;
        logic       wr_en;
        logic [1:0] wr_addr;
    } obs_t;

    typedef struct {
        int   test;
        int   cyc;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [1:0] op0, op1;

    logic       busy0, done0, err0, rd_en0, mabs0, madd0;
    logic       acc_en0, acc_clr0, wr_en0;
    logic [1:0] rd_row0, rd_col0, wr_addr0;

    logic       busy1, done1, err1, rd_en1, mabs1, madd1;
    logic       acc_en1, acc_clr1, wr_en1;
    logic       rd_row1, rd_col1, wr_addr1;

    obs_t trace [5][32];
    vec_t vecs [$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   ncyc [5] = '{23, 11, 11, 24, 10};

    always #5 clk = ~clk;

    qsv_mac_ctrl #(.N_QUBITS(2), .MUL_LAT(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0),
        .busy(busy0), .done(done0), .err(err0),
        .rd_en(rd_en0), .rd_row(rd_row0), .rd_col(rd_col0),
        .mode_abs(mabs0), .mode_add(madd0),
        .acc_en(acc_en0), .acc_clr(acc_clr0),
        .wr_en(wr_en0), .wr_addr(wr_addr0)
    );

    qsv_mac_ctrl #(.N_QUBITS(1), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1),
        .busy(busy1), .done(done1), .err(err1),
        .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1),
        .mode_abs(mabs1), .mode_add(madd1),
        .acc_en(acc_en1), .acc_clr(acc_clr1),
        .wr_en(wr_en1), .wr_addr(wr_addr1)
    );

    function automatic obs_t sample(int t);
        obs_t s;
        if (t == 4) begin
            s = '{busy1, done1, err1, rd_en1, {1'b0, rd_row1},
                  {1'b0, rd_col1}, mabs1, madd1, acc_en1, acc_clr1,
                  wr_en1, {1'b0, wr_addr1}};
        end else begin
            s = '{busy0, done0, err0, rd_en0, rd_row0, rd_col0,
                  mabs0, madd0, acc_en0, acc_clr0, wr_en0, wr_addr0};
        end
        return s;
    endfunction

    // MATVEC, 2 qubits, PIPE=3, start sampled in cycle 0.
    function automatic obs_t exp_mat2(int c);
        obs_t e = '0;
        e.busy = (c >= 1 && c <= 20);
        if (c >= 1 && c <= 16) begin
            e.rd_en  = 1'b1;
            e.rd_row = 2'((c - 1) / 4);
            e.rd_col = 2'((c - 1) % 4);
        end
        if (c >= 4 && c <= 19) begin
            e.acc_en  = 1'b1;
            e.acc_clr = ((c - 4) % 4 == 0);
            e.wr_en   = ((c - 4) % 4 == 3);
            e.wr_addr = 2'((c - 4) / 4);
        end
        e.done = (c == 20);
        return e;
    endfunction

    // Element-wise runs (ABS/ADD/NORM), 2 qubits, PIPE=3.
    function automatic obs_t exp_elem(int k, bit abs_m, bit add_m, bit norm);
        obs_t e = '0;
        e.busy     = (k >= 1 && k <= 8);
        e.mode_abs = e.busy & abs_m;
        e.mode_add = e.busy & add_m;
        if (k >= 1 && k <= 4) begin
            e.rd_en  = 1'b1;
            e.rd_row = norm ? 2'd0 : 2'(k - 1);
            e.rd_col = 2'(k - 1);
        end
        if (k >= 4 && k <= 7) begin
            e.acc_en  = 1'b1;
            e.acc_clr = norm ? (k == 4) : 1'b1;
            e.wr_en   = norm ? (k == 7) : 1'b1;
            e.wr_addr = norm ? 2'd0 : 2'(k - 4);
        end
        e.done = (k == 8);
        return e;
    endfunction

    function automatic obs_t exp_of(int t, int c);
        obs_t e = '0;
        case (t)
            0: e = exp_mat2(c);
            1: e = exp_elem(c, 1'b1, 1'b0, 1'b0);
            2: begin
`ifdef QSV_NORM_EN
                e = exp_elem(c, 1'b1, 1'b0, 1'b1);
`else
                e.busy = (c == 1);
                e.done = (c == 1);
                e.err  = (c == 1);
`endif
            end
            3: begin
                if (c <= 9)
                    e = exp_mat2(c);
                else if (c >= 12)
                    e = exp_elem(c - 12, 1'b0, 1'b1, 1'b0);
            end
            default: begin
                e.busy = (c >= 1 && c <= 7);
                if (c >= 1 && c <= 4) begin
                    e.rd_en  = 1'b1;
                    e.rd_row = 2'((c - 1) / 2);
                    e.rd_col = 2'((c - 1) % 2);
                end
                if (c >= 3 && c <= 6) begin
                    e.acc_en  = 1'b1;
                    e.acc_clr = ((c - 3) % 2 == 0);
                    e.wr_en   = ((c - 3) % 2 == 1);
                    e.wr_addr = 2'((c - 3) / 2);
                end
                e.done = (c == 7);
            end
        endcase
        return e;
    endfunction

    task automatic drive(int t, int k);
        start0 = 1'b0;
        start1 = 1'b0;
        op0    = 2'b00;
        op1    = 2'b00;
        rst    = 1'b0;
        case (t)
            0: begin
                start0 = (k == 0 || k == 3 || k == 10);
                op0    = (k == 0) ? 2'b00 : 2'b10;
            end
            1: begin
                start0 = (k == 0);
                op0    = 2'b01;
            end
            2: begin
                start0 = (k == 0);
                op0    = 2'b11;
            end
            3: begin
                start0 = (k == 0 || k == 12);
                op0    = (k == 12) ? 2'b10 : 2'b00;
                rst    = (k == 9);
            end
            default: begin
                start1 = (k == 0);
                op1    = 2'b00;
            end
        endcase
    endtask

    task automatic check(string name, int t, int c, obs_t got, obs_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s test%0d cyc%0d: got %h want %h",
                     name, t, c, got, want);
        end
    endtask

    initial begin
        for (int t = 0; t < 5; t++)
            for (int c = 0; c < ncyc[t]; c++) begin
                vec_t v;
                v.test = t;
                v.cyc  = c;
                v.exp  = exp_of(t, c);
                vecs.push_back(v);
            end

        rst    = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        op0    = 2'b00;
        op1    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        check("reset_n2", -1, 0, sample(0), '0);
        check("reset_n1", -1, 0, sample(4), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < ncyc[t]; k++) begin
                drive(t, k);
                @(negedge clk);
                trace[t][k] = sample(t);
                @(posedge clk);
                #1;
            end
            drive(-1, 99);
            start1 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end

        foreach (vecs[i])
            check("trace", vecs[i].test, vecs[i].cyc,
                  trace[vecs[i].test][vecs[i].cyc], vecs[i].exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
